// File: rtl/sort_pkg.sv
// Shared definitions for the 16-entry index sorter and its result streamer.
// Holds batch defaults, the streamer state encoding and bus slicing helpers.
package sort_pkg;

    localparam int SORT_BIT_LEN = 18;
    localparam int SORT_NUMBER  = 16;
    localparam int SORT_IDX_W   = $clog2(SORT_NUMBER);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        STREAM  = 2'd3
    } state_e;

    // Low bit of slot `slot` on a flat bus of `width`-bit fields.
    function automatic int bus_lsb(input int slot, input int width);
        return slot * width;
    endfunction

    // Sorted-result slot that holds output rank `rank`.
    function automatic int slot_of_rank(
        input int rank,
        input int number,
        input bit descend
    );
        return descend ? (number - 1 - rank) : rank;
    endfunction

endpackage

// File: rtl/sort_edge_detect.sv
// Registered rising-edge detector for the sorter completion level.
// The rise pulse is registered, so it appears one cycle after the level.
module sort_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;
    logic rise_q;

    // Keep the previous level and register the level-rose pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= level_i;
            rise_q  <= level_i & ~level_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sort_result_streamer.sv
// Consumes the index sorter result and streams (value, index, rank)
// tuples over valid/ready, ascending or descending, truncated to TOP_K.
module sort_result_streamer
    import sort_pkg::*;
#(
    parameter int BIT_LEN = SORT_BIT_LEN,
    parameter int NUMBER  = SORT_NUMBER,
    parameter int IDX_W   = $clog2(NUMBER),
    parameter int TOP_K   = NUMBER,
    parameter bit DESCEND = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIT_LEN*NUMBER-1:0] data_in,
    input  logic                      done_sorting,
    input  logic [IDX_W*NUMBER-1:0]   sorted_index_1D,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [BIT_LEN-1:0] out_value,
    output logic [IDX_W-1:0]          out_index,
    output logic [IDX_W-1:0]          out_rank,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err_flag
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_RANK = CNT_W'(TOP_K - 1);

    state_e state_q, state_d;
    logic   done_rise;

    logic signed [BIT_LEN-1:0] val_q [NUMBER];
    logic [IDX_W-1:0]          idx_q [NUMBER];

    logic [CNT_W-1:0]          rank_q, rank_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic signed [BIT_LEN-1:0] value_q, value_d;
    logic [IDX_W-1:0]          index_q, index_d;
    logic                      err_q, err_d;

    logic                      load_val;
    logic                      load_idx;
    logic                      load_out;
    logic                      xfer;

    logic [CNT_W-1:0]          sel_rank;
    logic [IDX_W-1:0]          sel_slot;
    logic [IDX_W-1:0]          sel_idx;
    logic signed [BIT_LEN-1:0] sel_val;

    sort_edge_detect u_done_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (done_sorting),
        .rise_o  (done_rise)
    );

    assign xfer = valid_q & out_ready;

    // Pick the tuple for the next rank; in CAPTURE read the live sorter bus.
    always_comb begin
        sel_rank = '0;
        if (state_q != CAPTURE) begin
            sel_rank = rank_q + 1'b1;
        end
        sel_slot = IDX_W'(slot_of_rank(int'(sel_rank), NUMBER, DESCEND));
        if (state_q == CAPTURE) begin
            sel_idx = sorted_index_1D[bus_lsb(int'(sel_slot), IDX_W) +: IDX_W];
        end else begin
            sel_idx = idx_q[sel_slot];
        end
        sel_val = val_q[sel_idx];
    end

    // Next state, output register loads and sticky error.
    always_comb begin
        state_d  = state_q;
        rank_d   = rank_q;
        valid_d  = valid_q;
        value_d  = value_q;
        index_d  = index_q;
        err_d    = err_q;
        load_val = 1'b0;
        load_idx = 1'b0;
        load_out = 1'b0;

        if (start) begin
            state_d  = ARMED;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            load_val = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (done_rise) err_d = 1'b1;
                end
                ARMED: begin
                    if (done_rise) state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (done_rise) err_d = 1'b1;
                    load_idx = 1'b1;
                    load_out = 1'b1;
                    rank_d   = '0;
                    valid_d  = 1'b1;
                    state_d  = STREAM;
                end
                STREAM: begin
                    if (done_rise) err_d = 1'b1;
                    if (xfer) begin
                        if (last_q) begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            load_out = 1'b1;
                            rank_d   = rank_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load_out) begin
            value_d = sel_val;
            index_d = sel_idx;
        end
        last_d = load_out ? (rank_d == LAST_RANK) : last_q;
    end

    // State, output tuple and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rank_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            value_q <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            value_q <= value_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    // Value store, filled from the unsorted vector on start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUMBER; i++) val_q[i] <= '0;
        end else if (load_val) begin
            for (int i = 0; i < NUMBER; i++) begin
                val_q[i] <= data_in[bus_lsb(i, BIT_LEN) +: BIT_LEN];
            end
        end
    end

    // Index store, filled from the sorter result on leaving CAPTURE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUMBER; i++) idx_q[i] <= '0;
        end else if (load_idx) begin
            for (int i = 0; i < NUMBER; i++) begin
                idx_q[i] <= sorted_index_1D[bus_lsb(i, IDX_W) +: IDX_W];
            end
        end
    end

    assign out_valid = valid_q;
    assign out_value = value_q;
    assign out_index = index_q;
    assign out_rank  = rank_q[IDX_W-1:0];
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign err_flag  = err_q;

endmodule

// File: tb/tb_sort_result_streamer.sv
// Scoreboard bench for sort_result_streamer: an ascending full-width
// instance and a descending TOP_K=3 instance share one stimulus stream.
module tb_sort_result_streamer;

    localparam int BL = 18;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int K1 = 3;

    typedef struct {
        int v;
        int idx;
        int rank;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic done_sorting = 1'b0;
    logic out_ready = 1'b0;
    logic [BL*N-1:0] data_in = '0;
    logic [IW*N-1:0] sorted_index_1D = '0;

    logic v0, last0, busy0, err0;
    logic signed [BL-1:0] val0;
    logic [IW-1:0] idx0, rank0;
    logic v1, last1, busy1, err1;
    logic signed [BL-1:0] val1;
    logic [IW-1:0] idx1, rank1;

    int vals[N];
    beat_t q0[$];
    beat_t q1[$];
    int npass = 0;
    int total = 0;
    int rmode = 0;

    sort_result_streamer u0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .done_sorting(done_sorting), .sorted_index_1D(sorted_index_1D),
        .out_valid(v0), .out_ready(out_ready), .out_value(val0),
        .out_index(idx0), .out_rank(rank0), .out_last(last0),
        .busy(busy0), .err_flag(err0)
    );

    sort_result_streamer #(.TOP_K(K1), .DESCEND(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .done_sorting(done_sorting), .sorted_index_1D(sorted_index_1D),
        .out_valid(v1), .out_ready(out_ready), .out_value(val1),
        .out_index(idx1), .out_rank(rank1), .out_last(last1),
        .busy(busy1), .err_flag(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sorter model: stable ascending order, then expected beats per DUT.
    task automatic load_batch();
        int ord[N];
        bit used[N];
        int best;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int r = 0; r < N; r++) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i] && (best < 0 || vals[i] < vals[best])) best = i;
            end
            ord[r] = best;
            used[best] = 1'b1;
        end
        for (int i = 0; i < N; i++) data_in[i*BL +: BL] = vals[i][BL-1:0];
        for (int r = 0; r < N; r++) sorted_index_1D[r*IW +: IW] = ord[r][IW-1:0];
        q0.delete();
        q1.delete();
        for (int r = 0; r < N; r++)
            q0.push_back('{vals[ord[r]], ord[r], r, (r == N-1)});
        for (int r = 0; r < K1; r++)
            q1.push_back('{vals[ord[N-1-r]], ord[N-1-r], r, (r == K1-1)});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fire_done(input int hold);
        done_sorting = 1'b1;
        repeat (hold) tick();
        done_sorting = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((busy0 || busy1) && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_idle"}, int'(busy0 || busy1), 0);
        chk({name, "_q0_left"}, q0.size(), 0);
        chk({name, "_q1_left"}, q1.size(), 0);
    endtask

    function automatic int rnd_val();
        logic [BL-1:0] r;
        r = BL'($urandom);
        return int'($signed(r));
    endfunction

    // Downstream ready driver.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph % 3 == 0); ph++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor for the ascending instance.
    always @(negedge clk) begin
        beat_t e;
        if (rst && v0 && out_ready && !start) begin
            if (q0.size() == 0) begin
                chk("u0_extra_beat", int'(rank0), -1);
            end else begin
                e = q0.pop_front();
                chk("u0_value", int'(val0), e.v);
                chk("u0_index", int'(idx0), e.idx);
                chk("u0_rank", int'(rank0), e.rank);
                chk("u0_last", int'(last0), int'(e.last));
            end
        end
    end

    // Monitor for the descending TOP_K instance.
    always @(negedge clk) begin
        beat_t e;
        if (rst && v1 && out_ready && !start) begin
            if (q1.size() == 0) begin
                chk("u1_extra_beat", int'(rank1), -1);
            end else begin
                e = q1.pop_front();
                chk("u1_value", int'(val1), e.v);
                chk("u1_index", int'(idx1), e.idx);
                chk("u1_rank", int'(rank1), e.rank);
                chk("u1_last", int'(last1), int'(e.last));
            end
        end
    end

    initial begin
        int k;
        bit seen;

        // Reset values.
        repeat (3) tick();
        chk("rst_valid0", int'(v0), 0);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_err0", int'(err0), 0);
        chk("rst_value0", int'(val0), 0);
        chk("rst_rank0", int'(rank0), 0);
        chk("rst_last0", int'(last0), 0);
        chk("rst_valid1", int'(v1), 0);
        rst = 1'b1;
        tick();

        // Reverse-ordered batch, done held 3 cycles, latency check.
        rmode = 0;
        for (int i = 0; i < N; i++) vals[i] = 15 - i;
        load_batch();
        chk("armed_busy", int'(busy0), 1);
        done_sorting = 1'b1;
        tick();
        chk("lat_t", int'(v0), 0);
        tick();
        chk("lat_t1", int'(v0), 0);
        tick();
        chk("lat_t2", int'(v0), 1);
        chk("lat_t2_rank", int'(rank0), 0);
        done_sorting = 1'b0;
        wait_idle("rev", 200);
        chk("rev_err0", int'(err0), 0);
        chk("rev_err1", int'(err1), 0);

        // Signed extremes with backpressure.
        rmode = 1;
        for (int i = 0; i < N; i++) vals[i] = $urandom_range(0, 2000) - 1000;
        vals[3] = -5;
        vals[9] = 131071;
        vals[12] = -131072;
        load_batch();
        fire_done(2);
        wait_idle("ext", 400);
        chk("ext_valid1", int'(v1), 0);

        // Random batches, random ready, some with ties.
        rmode = 2;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < N; i++)
                vals[i] = (b == 1) ? $urandom_range(0, 3) : rnd_val();
            load_batch();
            repeat ($urandom_range(0, 3)) tick();
            fire_done($urandom_range(1, 4));
            wait_idle("rnd", 600);
        end

        // Spurious done while idle.
        rmode = 0;
        fire_done(1);
        repeat (3) tick();
        chk("spur_err0", int'(err0), 1);
        chk("spur_err1", int'(err1), 1);
        chk("spur_valid0", int'(v0), 0);
        for (int i = 0; i < N; i++) vals[i] = rnd_val();
        load_batch();
        chk("spur_clr0", int'(err0), 0);
        chk("spur_clr1", int'(err1), 0);
        fire_done(1);
        wait_idle("spur", 200);

        // Abort at rank 7.
        for (int i = 0; i < N; i++) vals[i] = rnd_val();
        load_batch();
        fire_done(1);
        k = 0;
        while (!(v0 && rank0 == 4'd7) && k < 100) begin
            tick();
            k++;
        end
        chk("abort_reach7", int'(v0 && rank0 == 4'd7), 1);
        for (int i = 0; i < N; i++) vals[i] = rnd_val();
        load_batch();
        chk("abort_valid", int'(v0), 0);
        chk("abort_busy", int'(busy0), 1);
        fire_done(2);
        wait_idle("abort", 200);

        // Async reset mid-stream.
        for (int i = 0; i < N; i++) vals[i] = rnd_val();
        load_batch();
        fire_done(1);
        k = 0;
        while (!(v0 && rank0 == 4'd5) && k < 100) begin
            tick();
            k++;
        end
        chk("arst_reach5", int'(v0 && rank0 == 4'd5), 1);
        #3;
        rst = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk("arst_valid", int'(v0), 0);
        chk("arst_busy", int'(busy0), 0);
        chk("arst_rank", int'(rank0), 0);
        chk("arst_value", int'(val0), 0);
        chk("arst_index", int'(idx0), 0);
        #10;
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | v0 | v1;
        end
        chk("arst_no_resume", int'(seen), 0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule

// File: doc/sort_result_streamer.md
Name: sort_result_streamer

Overview:
- Reader/consumer for the 16-entry index sorter's result interface.
- Captures the unsorted value vector on start, then waits for the sorter's done_sorting rising edge and captures sorted_index_1D one cycle later.
- Streams (value, original index, rank) tuples one per cycle over a valid/ready handshake, ascending or descending, truncated to TOP_K entries.
- Sits between the sorter and downstream selection/decision logic.

Parameters:
BIT_LEN, 18, width of each signed value
NUMBER, 16, entries per sort batch (power of two)
IDX_W, 4, index width, log2(NUMBER)
TOP_K, 16, beats emitted per batch (1..NUMBER)
DESCEND, 0, 0 = rank 0 is the smallest value; 1 = rank 0 is the largest value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  new batch; same pulse that launches the sorter
data_in  in  BIT_LEN*NUMBER  unsorted signed values, entry i at [i*BIT_LEN +: BIT_LEN]
done_sorting  in  1  sorter completion level (may stay high several cycles)
sorted_index_1D  in  IDX_W*NUMBER  sorter result, ascending, slot r at [r*IDX_W +: IDX_W]
out_valid  out  1  output tuple valid
out_ready  in  1  downstream accepts
out_value  out  BIT_LEN  signed value of current rank
out_index  out  IDX_W  original position of that value
out_rank  out  IDX_W  rank 0..TOP_K-1
out_last  out  1  high with final beat (rank TOP_K-1)
busy  out  1  state != IDLE
err_flag  out  1  sticky: done edge while not ARMED; cleared only by reset or start

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid=0, out_value=0, out_index=0, out_rank=0, out_last=0, busy=0, err_flag=0; value/index stores=0; done edge detector history=0.
- FSM states: IDLE, ARMED, CAPTURE, STREAM.
- start=1 in any state, sampled at an edge:
  - load all NUMBER values from data_in, clear err_flag, go ARMED.
  - drop out_valid next cycle. Abort overrides the handshake; a beat pending in that cycle is discarded even if out_ready=1.
- Done edge: done_rise = done_sorting & ~done_q, where done_q is a registered copy of done_sorting.
  - ARMED + done_rise: go CAPTURE.
  - CAPTURE, next edge: latch sorted_index_1D (the sorter output is valid one cycle after done_sorting), set rank=0, go STREAM. Load the output registers with rank 0 at this same edge, so out_valid rises at this edge.
  - Latency: done_sorting sampled high at edge t gives out_valid=1 after edge t+2.
- done_rise in IDLE, CAPTURE or STREAM: ignored; err_flag set.
- start and done_rise on the same edge: start wins and done_rise is ignored (no err_flag).
- Slot selection: rank r reads slot s = r when DESCEND=0, s = NUMBER-1-r when DESCEND=1.
  - out_index = stored_index[s].
  - out_value = stored_value[out_index], unmodified two's-complement.
- Handshake:
  - Outputs are registered and hold stable while out_valid=1 and out_ready=0.
  - A transfer occurs on an edge with out_valid and out_ready both high.
  - On transfer at rank r < TOP_K-1: load rank r+1 at the same edge, giving one beat per cycle with out_ready held high.
  - out_last = (out_rank == TOP_K-1).
  - On transfer of the last beat: out_valid=0 and state IDLE at that edge; out_value/out_index/out_rank hold their last values.
- out_ready is ignored when out_valid=0.
- Rank counter is IDX_W+1 bits wide internally so TOP_K=NUMBER cannot wrap.
- Reset asserted mid-stream: immediate return to IDLE and reset values; no partial beat is emitted.

Decomposition:
- Shared package sort_pkg:
  - BIT_LEN and NUMBER defaults, IDX_W derivation.
  - state enum {IDLE, ARMED, CAPTURE, STREAM}.
  - slot-to-bus-offset helper functions shared with the sorter.
- One natural sub-module: sort_edge_detect (registered done_q plus rise pulse, async active-low reset).
- Value/index stores and the output mux stay inline.

Test Plan:
- Reset, then start with data_in = {15,14,...,0} (entry i = 15-i); sorter result slot r = 15-r; done held high 3 cycles; out_ready=1 -> first out_valid 2 edges after done; 16 beats of (value r, index 15-r, rank r); out_last on rank 15 only; err_flag stays 0.
- DESCEND=1, TOP_K=3, values including -5, 131071, -131072 -> beats in order: 131071, next-largest, next-largest; out_last on rank 2; then IDLE, busy=0.
- Backpressure: toggle out_ready 1,0,0,1,... -> outputs are stable during stalls; no beat duplicated or skipped; total beats = TOP_K.
- Spurious done: done_sorting pulse in IDLE -> err_flag=1, out_valid stays 0; next start clears err_flag.
- Abort: start asserted at rank 7 with out_ready=1 -> out_valid=0 next cycle, state ARMED; after the next done, the new batch streams from rank 0.
- Async reset dropped low mid-stream, between clock edges -> all outputs 0 immediately; streaming does not resume after reset is released.
